// File: rtl/panda_data_bus_bridge_if.sv
// Core data port and OBI-style request/grant memory bus, bundled for the bridge.
// The slave modport is the bridge's view; master is the core+memory environment's view.
interface panda_data_bus_bridge_if;
    logic        core_req_i;
    logic [31:0] core_addr_i;
    logic [3:0]  core_we_i;
    logic [31:0] core_wdata_i;
    logic [31:0] core_rdata_o;
    logic        core_stall_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  core_req_i, core_addr_i, core_we_i, core_wdata_i,
        output core_rdata_o, core_stall_o, bus_err_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output core_req_i, core_addr_i, core_we_i, core_wdata_i,
        input  core_rdata_o, core_stall_o, bus_err_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/panda_data_bus_bridge.sv
// Core data port to request/grant bus bridge: min 3-cycle access (IDLE, REQ+gnt, DONE),
// core stalled until DONE; watchdog aborts an access stuck in REQ/WAIT with a sticky error.
module panda_data_bus_bridge #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    panda_data_bus_bridge_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] CntLast = 16'(TimeoutCycles - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic        w_cnt_last;
    logic        w_rdata_ld;
    logic        w_timeout;
    logic        w_capture;

    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_core_rdata;
    logic        r_bus_err;

    // >= rather than == so an access granted right at the limit still times out in WAIT.
    assign w_cnt_last = (r_cnt >= CntLast);
    assign w_capture  = (r_state == IDLE) && bus.core_req_i;

    always_comb begin
        w_state_nxt = r_state;
        w_rdata_ld  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.core_req_i) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt_i) begin
                    if (r_mem_we) begin
                        w_state_nxt = DONE;
                    end else if (bus.mem_rvalid_i) begin
                        w_state_nxt = DONE;
                        w_rdata_ld  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end else if (w_cnt_last) begin
                    w_state_nxt = DONE;
                    w_timeout   = 1'b1;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    w_state_nxt = DONE;
                    w_rdata_ld  = 1'b1;
                end else if (w_cnt_last) begin
                    w_state_nxt = DONE;
                    w_timeout   = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every access passes through IDLE, so holding the counter at zero there clears it on REQ entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= 16'd0;
        end else if (r_state == REQ || r_state == WAIT) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= 16'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem_addr  <= 32'd0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else if (w_capture) begin
            r_mem_addr  <= bus.core_addr_i & 32'hFFFF_FFFC;
            r_mem_we    <= |bus.core_we_i;
            r_mem_be    <= (|bus.core_we_i) ? bus.core_we_i : 4'hF;
            r_mem_wdata <= bus.core_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_core_rdata <= 32'd0;
            r_bus_err    <= 1'b0;
        end else begin
            if (w_rdata_ld) begin
                r_core_rdata <= bus.mem_rdata_i;
            end else if (w_timeout) begin
                r_core_rdata <= 32'd0;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus.mem_req_o    = (r_state == REQ);
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_we_o     = r_mem_we;
    assign bus.mem_be_o     = r_mem_be;
    assign bus.mem_wdata_o  = r_mem_wdata;
    assign bus.core_rdata_o = r_core_rdata;
    assign bus.bus_err_o    = r_bus_err;
    assign bus.core_stall_o = bus.core_req_i && (r_state != DONE);

endmodule
